// File: rtl/dino_pkg.sv
// Shared types, constants and helpers for the Dino Run game-play core.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam int DEF_HACTIVE = 1280;

  localparam logic [7:0] LFSR_SEED = 8'hAD;
  // x^8+x^6+x^5+x^4+1 for a left-shifting register: feedback from bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned n);
    return (v << (n % 8)) | (v >> (8 - (n % 8)));
  endfunction

  // Axis-aligned overlap of box a against box b. Coordinates arrive
  // zero-extended to 16 bits and edges are summed one bit wider so that
  // x+w / y+h never wrap.
  function automatic logic aabb_hit(input logic [15:0] ax, aw, ay, ah,
                                    input logic [15:0] bx, bw, by, bh);
    logic [16:0] a_r, b_r, a_b, b_b;
    a_r = {1'b0, ax} + {1'b0, aw};
    b_r = {1'b0, bx} + {1'b0, bw};
    a_b = {1'b0, ay} + {1'b0, ah};
    b_b = {1'b0, by} + {1'b0, bh};
    return ({1'b0, ax} < b_r) && (a_r > {1'b0, bx}) &&
           ({1'b0, ay} < b_b) && (a_b > {1'b0, by});
  endfunction

endpackage

// File: rtl/obstacle_engine_if.sv
// Bundle between the controller/dino logic, the engine and the sprite renderer.
// start is a level request sampled on every clk edge; there is no valid/ready
// pairing: every engine output is a registered value readable at any time.
interface obstacle_engine_if #(
  parameter int NUM_OBS      = 4,
  parameter int X_W          = 12,
  parameter int Y_W          = 10,
  parameter int SCORE_DIGITS = 5
);
  logic                      start;
  logic [X_W-1:0]            dino_x;
  logic [Y_W-1:0]            dino_y;
  logic [7:0]                dino_w;
  logic [7:0]                dino_h;
  logic [NUM_OBS*Y_W-1:0]    obs_y;
  logic [NUM_OBS*8-1:0]      obs_w;
  logic [NUM_OBS*8-1:0]      obs_h;
  logic [NUM_OBS*X_W-1:0]    obs_x;
  logic [1:0]                state;
  logic [3:0]                speed;
  logic [4*SCORE_DIGITS-1:0] score_bcd;
  logic [NUM_OBS-1:0]        hit_mask;
  logic                      tick;
  logic [1:0]                anim_phase;

  modport master (
    input  start, dino_x, dino_y, dino_w, dino_h, obs_y, obs_w, obs_h,
    output obs_x, state, speed, score_bcd, hit_mask, tick, anim_phase
  );

  modport slave (
    output start, dino_x, dino_y, dino_w, dino_h, obs_y, obs_w, obs_h,
    input  obs_x, state, speed, score_bcd, hit_mask, tick, anim_phase
  );
endinterface

// File: rtl/obstacle_engine_bcd_counter.sv
// Multi-digit BCD up-counter; all-nines wraps to zero.
module bcd_counter #(
  parameter int SCORE_DIGITS = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clr,
  input  logic                      inc,
  output logic [4*SCORE_DIGITS-1:0] bcd
);
  logic [4*SCORE_DIGITS-1:0] bcd_d;

  // Ripple the carry from digit 0 upward; a 9 with carry-in rolls to 0.
  always_comb begin
    logic carry;
    bcd_d = bcd;
    carry = inc;
    for (int d = 0; d < SCORE_DIGITS; d++) begin
      if (carry) begin
        if (bcd[d*4 +: 4] == 4'd9) begin
          bcd_d[d*4 +: 4] = 4'd0;
        end else begin
          bcd_d[d*4 +: 4] = bcd[d*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Score register, cleared by reset or a new game.
  always_ff @(posedge clk) begin
    if (!reset_n || clr) bcd <= '0;
    else                 bcd <= bcd_d;
  end
endmodule

// File: rtl/obstacle_engine.sv
// Dino Run game-play core: scrolling obstacle channels, LFSR respawn,
// speed ramp, AABB collision and IDLE/RUN/OVER game state.
module obstacle_engine
  import dino_pkg::*;
#(
  parameter int NUM_OBS        = 4,
  parameter int X_W            = 12,
  parameter int Y_W            = 10,
  parameter int HACTIVE        = DEF_HACTIVE,
  parameter int SPAWN_GAP      = 200,
  parameter int TICK_DIV       = 2_000_000,
  parameter int PASS_PER_LEVEL = 12,
  parameter int MAX_SPEED      = 8,
  parameter int SCORE_DIGITS   = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  obstacle_engine_if.master bus
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  game_state_t        state_q, state_d;
  logic               reload;
  logic [CNT_W-1:0]   cnt_q;
  logic [7:0]         lfsr_q;
  logic [3:0]         speed_q;
  logic [7:0]         pass_q, n_resp, pass_sum;
  logic               level_up;
  logic [NUM_OBS-1:0] hit_v, resp_v, hit_mask_q;
  logic               any_hit, tick_adv, tick_q;
  logic [1:0]         anim_q;

  // A hit in the same cycle as a tick suppresses the tick's updates.
  assign any_hit  = (state_q == RUN) && (|hit_v);
  assign tick_adv = (state_q == RUN) && (cnt_q == CNT_W'(TICK_DIV - 1)) && !(|hit_v);

  for (genvar i = 0; i < NUM_OBS; i++) begin : g_ch
    localparam logic [X_W-1:0] INIT_X = X_W'(HACTIVE - 80 + i * SPAWN_GAP);
    logic [X_W-1:0] x_q, spawn_x;
    logic [5:0]     sel;

    assign sel       = 6'(rotl8(lfsr_q, i));
    assign spawn_x   = X_W'(HACTIVE) + X_W'({sel, 4'b0000});
    assign resp_v[i] = (x_q <= X_W'(speed_q));
    assign hit_v[i]  = aabb_hit(16'(bus.dino_x), 16'(bus.dino_w),
                                16'(bus.dino_y), 16'(bus.dino_h),
                                16'(x_q), 16'(bus.obs_w[i*8 +: 8]),
                                16'(bus.obs_y[i*Y_W +: Y_W]), 16'(bus.obs_h[i*8 +: 8]));
    assign bus.obs_x[i*X_W +: X_W] = x_q;

    // Channel position: reload on new game, scroll or respawn on each tick.
    always_ff @(posedge clk) begin
      if (!reset_n || reload) x_q <= INIT_X;
      else if (tick_adv)      x_q <= resp_v[i] ? spawn_x : x_q - X_W'(speed_q);
    end
  end

  // Next-state logic; entering RUN from IDLE or OVER reloads the game.
  always_comb begin
    state_d = state_q;
    reload  = 1'b0;
    case (state_q)
      IDLE:    if (bus.start) begin state_d = RUN; reload = 1'b1; end
      RUN:     if (any_hit)   state_d = OVER;
      OVER:    if (bus.start) begin state_d = RUN; reload = 1'b1; end
      default: state_d = IDLE;
    endcase
  end

  // Game state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Motion tick divider, running only while RUN.
  always_ff @(posedge clk) begin
    if (!reset_n || reload) cnt_q <= '0;
    else if (state_q == RUN) cnt_q <= (cnt_q == CNT_W'(TICK_DIV - 1)) ? '0 : cnt_q + 1'b1;
  end

  // Respawns this tick, added to the running pass count.
  always_comb begin
    n_resp = '0;
    for (int k = 0; k < NUM_OBS; k++) n_resp = n_resp + 8'(resp_v[k]);
    pass_sum = pass_q + n_resp;
    level_up = (pass_sum >= 8'(PASS_PER_LEVEL));
  end

  // Pass counter and speed ramp; the counter clears on level-up even at max speed.
  always_ff @(posedge clk) begin
    if (!reset_n || reload) begin
      pass_q  <= '0;
      speed_q <= 4'd1;
    end else if (tick_adv) begin
      pass_q <= level_up ? 8'd0 : pass_sum;
      if (level_up && (speed_q < 4'(MAX_SPEED))) speed_q <= speed_q + 4'd1;
    end
  end

  // Free-running randomness and animation phase, advanced per tick only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr_q <= LFSR_SEED;
      anim_q <= 2'd0;
    end else if (tick_adv) begin
      lfsr_q <= lfsr_next(lfsr_q);
      anim_q <= anim_q + 2'd1;
    end
  end

  // Registered tick pulse and sticky hit mask.
  always_ff @(posedge clk) begin
    if (!reset_n) tick_q <= 1'b0;
    else          tick_q <= tick_adv;
    if (!reset_n || reload) hit_mask_q <= '0;
    else if (any_hit)       hit_mask_q <= hit_v;
  end

  bcd_counter #(.SCORE_DIGITS(SCORE_DIGITS)) u_score (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (reload),
    .inc     (tick_adv),
    .bcd     (bus.score_bcd)
  );

  assign bus.state      = state_q;
  assign bus.speed      = speed_q;
  assign bus.hit_mask   = hit_mask_q;
  assign bus.tick       = tick_q;
  assign bus.anim_phase = anim_q;
endmodule

// File: doc/obstacle_engine.md
Name: obstacle_engine

Overview:
- Parametrised game-play core for Dino Run: NUM_OBS independently scrolling obstacle channels, LFSR-randomised respawn, level-based speed ramp, and per-channel AABB collision against the dino box.
- Adds an IDLE/RUN/OVER state machine and a BCD score counter.
- Sits between the controller decoder and the VGA sprite renderer; the renderer only reads positions, state, score and anim_phase.

Parameters:
- NUM_OBS, 4, number of obstacle channels.
- X_W, 12, width of each obstacle x coordinate.
- Y_W, 10, width of y coordinates.
- HACTIVE, 1280, visible line width; respawn base.
- SPAWN_GAP, 200, initial spacing: obstacle i starts at HACTIVE - 80 + i*SPAWN_GAP.
- TICK_DIV, 2_000_000, clk cycles per motion tick.
- PASS_PER_LEVEL, 12, respawns needed per speed increment.
- MAX_SPEED, 8, speed saturation value (pixels/tick).
- SCORE_DIGITS, 5, number of BCD score digits.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  start/replay request (controller_report[4]), level sensitive.
- dino_x  in  X_W  dino left edge.
- dino_y  in  Y_W  dino top edge.
- dino_w  in  8  dino width.
- dino_h  in  8  dino height.
- obs_y  in  NUM_OBS*Y_W  per-channel top edge, flattened, channel 0 in LSBs.
- obs_w  in  NUM_OBS*8  per-channel width.
- obs_h  in  NUM_OBS*8  per-channel height.
- obs_x  out  NUM_OBS*X_W  per-channel left edge.
- state  out  2  0=IDLE, 1=RUN, 2=OVER.
- speed  out  4  current pixels/tick.
- score_bcd  out  4*SCORE_DIGITS  BCD score, digit 0 in LSBs.
- hit_mask  out  NUM_OBS  channel(s) that caused game over; sticky in OVER.
- tick  out  1  one-cycle pulse per motion tick while RUN.
- anim_phase  out  2  increments per tick, for pterodactyl frame select.

Behaviour:
- Reset (reset_n=0 at a clk edge) sets:
  - state=IDLE, speed=1, score=0, hit_mask=0, anim_phase=0, tick=0.
  - tick counter=0, pass_cnt=0, lfsr=8'hAD.
  - obs_x[i]=initial position.
- Reset mid-operation has priority over every other event.
- FSM:
  - IDLE: start=1 -> RUN.
  - RUN: any hit -> OVER.
  - OVER: start=1 -> RUN, reloading initial positions, speed=1, score=0, pass_cnt=0 and hit_mask=0, all in the same cycle.
  - IDLE->RUN also reloads these.
  - No other transitions.
- Tick counter:
  - Counts only in RUN.
  - On reaching TICK_DIV-1 it returns to 0 and asserts tick for that cycle.
  - Frozen in IDLE/OVER; cleared on entering RUN.
- On tick, for each channel i:
  - If obs_x[i] <= speed, respawn at HACTIVE + ({lfsr rotated left by i}[5:0] << 4). Maximum value is 2288, so it fits X_W=12.
  - Otherwise obs_x[i] -= speed.
  - Every respawn uses the pre-advance lfsr value.
- On tick, globally:
  - lfsr advances (x^8+x^6+x^5+x^4+1, shift left); it never reaches 0.
  - anim_phase increments, wrapping.
  - Score +1 in BCD; all digits 9 wraps to 0.
- Pass counting:
  - pass_cnt += popcount(respawns this tick).
  - If the new pass_cnt >= PASS_PER_LEVEL: speed = min(speed+1, MAX_SPEED) and pass_cnt=0, with any excess discarded.
  - At MAX_SPEED, pass_cnt still clears.
- Collision:
  - Evaluated every RUN cycle on the registered obs_x and dino inputs.
  - Test: ax<bx+bw && ax+aw>bx && ay<by+bh && ay+ah>by.
  - Sums are computed at X_W+1 / Y_W+1 bits; no wrap.
  - Hit registers to hit_mask and state=OVER on the next edge (1-cycle latency).
- If hit and tick occur in the same cycle, the hit wins: positions, score, speed, lfsr and anim_phase do not update.
- OVER: all outputs hold (score frozen).
- start held continuously causes immediate restart after OVER. Debouncing belongs to the controller block.
- Outputs are all registered; no combinational input-to-output paths.

Decomposition:
- dino_pkg holds:
  - game_state_t enum (IDLE, RUN, OVER).
  - HACTIVE.
  - LFSR seed and taps constants.
  - aabb_hit function.
- One sub-module: bcd_counter (SCORE_DIGITS param; inc, clr, bcd out; ripple-carry per digit with wrap).
- Channel update logic is a generate loop inside obstacle_engine.

Test Plan:
- Bench parameters: TICK_DIV=4, NUM_OBS=4. Dino at x=100, y=348, 32x32. Obstacles: y=248, 32x32.
- Reset then start=1 for 1 cycle -> state=RUN. First tick pulse 4 cycles later. obs_x[0] goes 1200->1199, and score_bcd=0x00001 after that tick.
- Force obs_x[0]=1 at speed=1 on tick with lfsr=8'hAD -> respawn at 1280+(0x2D<<4)=2000, pass_cnt=1. Run 12 respawns -> speed=2, pass_cnt=0.
- Set obs_y[2]=348 and let channel 2 scroll to x=131 -> hit_mask=4'b0100, state=OVER one cycle after overlap. Score and positions then hold for 100 cycles.
- Score preloaded to 99999, tick -> score_bcd=0. Speed at MAX_SPEED=8 plus 12 more respawns -> speed stays 8.
- In OVER, pulse start -> same cycle reload: obs_x = initial positions, speed=1, score=0, hit_mask=0, state=RUN. Assert reset_n=0 mid-RUN -> state=IDLE on the next edge.
